mem_access_ctrl: RTL and testbench

Initiator side of the data-memory port: accepts one load or store request at a time from the pipeline MEM stage and drives the memory's address, write data, active-low write strobe and active-low byte select. It captures the combinational read data, byte-extends it and returns exactly one response per request. It sits between the MEM pipeline register and the 16-bit data memory and stalls the pipeline through `req_ready` while an access is in flight.

---
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: pipeline request/response handshake plus the data-memory port.
// master is the environment (MEM stage and memory); slave is the controller itself.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_write_n;
  logic        mem_byte_n;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_addr, mem_wdata, mem_write_n, mem_byte_n
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_addr, mem_wdata, mem_write_n, mem_byte_n
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for a 16-bit data memory with byte extension,
// misalignment detection and a programmable number of wait states.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 0
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        signed_q, signed_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        in_access;
  logic        last_cycle;
  logic [15:0] load_value;

  assign in_access  = (state_q == StAccess);
  assign last_cycle = in_access && (wait_cnt_q == 4'd0);

  // Memory already zero-extends byte reads, so only signed byte loads need rework.
  always_comb begin
    load_value = bus.mem_rdata;
    if (byte_q && signed_q) begin
      load_value = {{8{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    byte_d      = byte_q;
    signed_d    = signed_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          write_d     = bus.req_write;
          byte_d      = bus.req_byte;
          signed_d    = bus.req_signed;
          resp_data_d = 16'h0000;
          if (!bus.req_byte && bus.req_addr[0]) begin
            // Misaligned word access: answer straight away, never touch memory.
            state_d    = StResp;
            resp_err_d = 1'b1;
          end else begin
            state_d    = StAccess;
            wait_cnt_d = WaitLoad;
            resp_err_d = 1'b0;
          end
        end
      end

      StAccess: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          if (!write_q) begin
            resp_data_d = load_value;
          end
        end
      end

      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 4'd0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      resp_data_q <= 16'h0000;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      byte_q      <= byte_d;
      signed_q    <= signed_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_data  = resp_data_q;
    bus.resp_err   = resp_err_q;

    bus.mem_addr    = in_access ? addr_q : 16'h0000;
    bus.mem_wdata   = in_access ? wdata_q : 16'h0000;
    bus.mem_byte_n  = in_access ? ~byte_q : 1'b1;
    // Reset gates the strobe combinationally so a write cannot land on a reset edge.
    bus.mem_write_n = ~(last_cycle && write_q) | rst;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl with a byte-array memory model and a
// behavioural reference that predicts data, error flag, response cycle and strobe count.
module tb_mem_access_ctrl;

  localparam int unsigned WS = 2;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
    int          strobes;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .WAIT_STATES (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] dev_mem [256];
  logic [7:0] ref_mem [256];
  exp_t       exp_q [$];
  exp_t       cur;
  bit         cur_ok;
  bit         in_resp;
  int         strobe_cnt;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  int          act_acc;
  logic [15:0] act_addr;
  logic [15:0] act_wdata;
  logic        act_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory device: combinational read, write on the rising edge while the strobe is low.
  always_comb begin
    if (!bus.mem_byte_n) begin
      bus.mem_rdata = {8'h00, dev_mem[bus.mem_addr[7:0]]};
    end else begin
      bus.mem_rdata = {dev_mem[{bus.mem_addr[7:1], 1'b1}], dev_mem[{bus.mem_addr[7:1], 1'b0}]};
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[0] = 8'h3C; dev_mem[1] = 8'hC3;
    dev_mem[4] = 8'h34; dev_mem[5] = 8'h12;
    dev_mem[6] = 8'hAD; dev_mem[7] = 8'hDE;
    dev_mem[8] = 8'hEF; dev_mem[9] = 8'hBE;
    for (int i = 0; i < 10; i++) ref_mem[i] = dev_mem[i];
    forever begin
      @(posedge clk);
      if (!bus.mem_write_n) begin
        if (!bus.mem_byte_n) begin
          dev_mem[bus.mem_addr[7:0]] = bus.mem_wdata[7:0];
        end else begin
          dev_mem[{bus.mem_addr[7:1], 1'b0}] = bus.mem_wdata[7:0];
          dev_mem[{bus.mem_addr[7:1], 1'b1}] = bus.mem_wdata[15:8];
        end
      end
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per response and checks it for every cycle it is held.
  initial begin
    in_resp    = 1'b0;
    cur_ok     = 1'b0;
    strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("wr_n_in_reset", 32'(bus.mem_write_n), 32'd1);
        in_resp    = 1'b0;
        strobe_cnt = 0;
      end else begin
        if (!bus.mem_write_n) begin
          strobe_cnt++;
          check("strobe_cycle", cyc, act_acc + 1 + int'(WS));
        end
        if (bus.req_ready) begin
          check("idle_mem_outputs",
                {bus.mem_addr, bus.mem_wdata[13:0], bus.mem_write_n, bus.mem_byte_n},
                {16'h0000, 14'h0000, 2'b11});
          check("idle_wdata_hi", 32'(bus.mem_wdata[15:14]), 32'd0);
        end
        if (!bus.req_ready && !bus.resp_valid) begin
          check("access_addr_byte", {bus.mem_addr, bus.mem_byte_n}, {act_addr, ~act_byte});
          check("access_wdata", 32'(bus.mem_wdata), 32'(act_wdata));
        end
        if (bus.resp_valid) begin
          check("ready_low_in_resp", 32'(bus.req_ready), 32'd0);
          if (!in_resp) begin
            in_resp = 1'b1;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              cur_ok = 1'b0;
              $display("FAIL unexpected_resp: got data %h err %b expected no response",
                       bus.resp_data, bus.resp_err);
            end else begin
              cur    = exp_q.pop_front();
              cur_ok = 1'b1;
              check("resp_cycle", cyc, cur.due);
              check("strobe_count", strobe_cnt, cur.strobes);
            end
            strobe_cnt = 0;
          end
          if (cur_ok) begin
            check("resp_data", 32'(bus.resp_data), 32'(cur.data));
            check("resp_err", 32'(bus.resp_err), 32'(cur.err));
          end
          if (bus.resp_ready) in_resp = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic b, input logic s, input logic [15:0] a,
                       input logic [15:0] wd, input bit track);
    bit         acc = 1'b0;
    exp_t       e;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] ai;
    @(posedge clk);
    #1;
    bus.req_write  = w;
    bus.req_byte   = b;
    bus.req_signed = s;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bus.req_ready) acc = 1'b1;
    end
    check("accept", 32'(acc), 32'd1);
    if (acc) begin
      act_acc   = cyc;
      act_addr  = a;
      act_byte  = b;
      act_wdata = wd;
      if (track) begin
        ai = a[7:0];
        if (!b && a[0]) begin
          e = '{data: 16'h0000, err: 1'b1, due: cyc + 1, strobes: 0};
        end else begin
          e = '{data: 16'h0000, err: 1'b0, due: cyc + 2 + int'(WS), strobes: int'(w)};
          if (w) begin
            ref_mem[ai] = wd[7:0];
            if (!b) ref_mem[ai + 8'd1] = wd[15:8];
          end else begin
            lo = ref_mem[ai];
            hi = ref_mem[ai + 8'd1];
            if (!b)     e.data = {hi, lo};
            else if (s) e.data = {{8{lo[7]}}, lo};
            else        e.data = {8'h00, lo};
          end
        end
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_byte   = 1'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = 16'($urandom);
    bus.req_wdata  = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || in_resp); i++) @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_resp", 32'(in_resp), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    act_acc        = -100;
    act_addr       = 16'h0000;
    act_wdata      = 16'h0000;
    act_byte       = 1'b0;
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0006;
    bus.req_wdata  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);

    issue(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b1);  // DEAD
    issue(1'b0, 1'b1, 1'b1, 16'h0006, 16'h0000, 1'b1);  // FFAD
    issue(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1);  // 00AD
    issue(1'b1, 1'b1, 1'b0, 16'h0004, 16'h5577, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1);  // 1277
    issue(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 16'h0007, 16'hFFFF, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b1);  // BEEF
    issue(1'b0, 1'b1, 1'b1, 16'h0009, 16'h0000, 1'b1);  // FFBE
    drain();

    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)),
            16'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    drain();

    // Word store aborted by reset exactly in its strobe cycle: nothing written, no response.
    issue(1'b1, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 1'b0);
    while (cyc < act_acc + 1 + int'(WS)) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 64; i++) begin
      check($sformatf("mem_byte_%0d", i), 32'(dev_mem[i]), 32'(ref_mem[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
